// File: rtl/mario_pkg.sv
// rtl/mario_pkg.sv - shared encodings for the Mario sprite-select sequencer
// Contents: pos encodings for the 4-to-1 sprite mux, the animation state enum,
// facing constants and a helper that builds the mux select.
package mario_pkg;

  localparam logic [2:0] POS_STDBACK  = 3'b000;
  localparam logic [2:0] POS_WKBACK   = 3'b001;
  localparam logic [2:0] POS_STDFRONT = 3'b010;
  localparam logic [2:0] POS_WKFRONT  = 3'b011;
  localparam int         POS_BLANK_BIT = 2;

  localparam logic FACE_LEFT  = 1'b0;
  localparam logic FACE_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WALK_WK  = 2'd1,
    WALK_STD = 2'd2,
    SKID     = 2'd3
  } anim_state_e;

  // Unblanked mux select for a given facing and walk frame.
  function automatic logic [2:0] pos_sel(input logic face, input logic wk);
    logic [2:0] sel;
    case ({face, wk})
      2'b00:   sel = POS_STDBACK;
      2'b01:   sel = POS_WKBACK;
      2'b10:   sel = POS_STDFRONT;
      default: sel = POS_WKFRONT;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mario_frame_counter.sv
// rtl/mario_frame_counter.sv - tick-qualified 8-bit frame counter
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (count resets to 0)
//   tick_i        : frame tick; counting only happens on ticks
//   clr_i         : load LOAD (any cycle, wins over counting)
//   en_i          : count enable, qualified by tick_i
//   cnt_o         : current count
//   term_o        : cnt_o == TERM
module mario_frame_counter #(
  parameter logic [7:0] TERM = 8'd0,
  parameter logic [7:0] LOAD = 8'd0,
  parameter bit         DOWN = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [7:0] cnt_o,
  output logic       term_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (tick_i && en_i) begin
      cnt_d = DOWN ? (cnt_q - 8'd1) : (cnt_q + 8'd1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/mario_anim_ctrl.sv
// rtl/mario_anim_ctrl.sv - Mario walk/skid animation sequencer driving the sprite mux
// Optional hurt blinking is built when MARIO_ANIM_BLINK_EN is defined.
// Ports:
//   clk25      : 25 MHz pixel clock
//   rst_n      : asynchronous active-low reset
//   frame_tick : one-cycle pulse per video frame; all timing counts these
//   move_left  : level, player holds left
//   move_right : level, player holds right
//   hurt       : one-cycle pulse, starts blinking (blink build only)
//   pos        : sprite select {blank, facing, walk frame}
//   facing     : 0 = left (back sprites), 1 = right (front sprites)
//   walking    : 1 while in a walk state
module mario_anim_ctrl
  import mario_pkg::*;
#(
  parameter int unsigned STEP_FRAMES  = 8,
  parameter int unsigned SKID_FRAMES  = 4,
  parameter int unsigned BLINK_FRAMES = 60
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       hurt,
  output logic [2:0] pos,
  output logic       facing,
  output logic       walking
);

  anim_state_e state_q, state_d;
  logic        facing_q, facing_d;
  logic [2:0]  pos_q;
  logic        walking_q;

  logic step_clr, step_inc, step_term;
  logic skid_clr, skid_inc, skid_term;
  logic [7:0] step_cnt, skid_cnt;
  logic [15:0] cnt_unused;

  // Both keys held decodes as no request.
  logic dir_valid, dir_face, dir_same, dir_opp;
  assign dir_valid = move_left ^ move_right;
  assign dir_face  = move_right ? FACE_RIGHT : FACE_LEFT;
  assign dir_same  = dir_valid && (dir_face == facing_q);
  assign dir_opp   = dir_valid && (dir_face != facing_q);

  always_comb begin
    state_d  = state_q;
    facing_d = facing_q;
    step_clr = 1'b0;
    step_inc = 1'b0;
    skid_clr = 1'b0;
    skid_inc = 1'b0;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (dir_same) begin
            state_d  = WALK_WK;
            step_clr = 1'b1;
          end else if (dir_opp) begin
            facing_d = ~facing_q;
            state_d  = SKID;
            skid_clr = 1'b1;
          end
        end
        WALK_WK, WALK_STD: begin
          if (dir_opp) begin
            facing_d = ~facing_q;
            state_d  = SKID;
            skid_clr = 1'b1;
          end else if (dir_same) begin
            if (step_term) begin
              state_d  = (state_q == WALK_WK) ? WALK_STD : WALK_WK;
              step_clr = 1'b1;
            end else begin
              step_inc = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        default: begin // SKID
          // A reversal mid-skid takes priority over finishing the skid.
          if (dir_opp) begin
            facing_d = ~facing_q;
            skid_clr = 1'b1;
          end else if (skid_term) begin
            state_d  = dir_same ? WALK_WK : IDLE;
            step_clr = dir_same;
          end else begin
            skid_inc = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      facing_q  <= FACE_RIGHT;
      pos_q     <= POS_STDFRONT;
      walking_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      facing_q  <= facing_d;
      pos_q     <= pos_sel(facing_d, state_d == WALK_WK);
      walking_q <= (state_d == WALK_WK) || (state_d == WALK_STD);
    end
  end

  mario_frame_counter #(
    .TERM (8'(STEP_FRAMES - 1)),
    .LOAD (8'd0),
    .DOWN (1'b0)
  ) u_step (
    .clk_i  (clk25),
    .rst_ni (rst_n),
    .tick_i (frame_tick),
    .clr_i  (step_clr),
    .en_i   (step_inc),
    .cnt_o  (step_cnt),
    .term_o (step_term)
  );

  mario_frame_counter #(
    .TERM (8'(SKID_FRAMES - 1)),
    .LOAD (8'd0),
    .DOWN (1'b0)
  ) u_skid (
    .clk_i  (clk25),
    .rst_ni (rst_n),
    .tick_i (frame_tick),
    .clr_i  (skid_clr),
    .en_i   (skid_inc),
    .cnt_o  (skid_cnt),
    .term_o (skid_term)
  );

  // Only the terminal flags drive the FSM; the raw counts are not needed here.
  assign cnt_unused = {step_cnt, skid_cnt};

`ifdef MARIO_ANIM_BLINK_EN
  logic [7:0] blink_cnt;
  logic       blink_zero;
  logic       blank;

  // Down-counter: hurt reloads on any cycle, ticks decrement until zero.
  mario_frame_counter #(
    .TERM (8'd0),
    .LOAD (8'(BLINK_FRAMES)),
    .DOWN (1'b1)
  ) u_blink (
    .clk_i  (clk25),
    .rst_ni (rst_n),
    .tick_i (frame_tick),
    .clr_i  (hurt),
    .en_i   (~blink_zero),
    .cnt_o  (blink_cnt),
    .term_o (blink_zero)
  );

  // Blank alternating 2-frame slots while the blink is running.
  assign blank = ~blink_zero & blink_cnt[1];
  assign pos   = pos_q | (3'(blank) << POS_BLANK_BIT);
`else
  logic hurt_unused;
  assign hurt_unused = hurt;
  assign pos         = pos_q;
`endif

  assign facing  = facing_q;
  assign walking = walking_q;

  always_ff @(posedge clk25) begin
    assert (STEP_FRAMES != 0 && SKID_FRAMES != 0)
      else $error("mario_anim_ctrl: STEP_FRAMES and SKID_FRAMES must be nonzero");
  end

endmodule
